// File: rtl/ex_wb_port_arbiter.sv
// Register-file write-port arbiter: buffered LSU load returns vs. EX ALU/MULT results.
// Optional performance counters are enabled by defining EX_WB_ARB_PERF_EN.
module ex_wb_port_arbiter #(
  parameter int LSU_DEPTH  = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_ready_i,
  input  logic        alu_valid_i,
  input  logic [5:0]  alu_waddr_i,
  input  logic [31:0] alu_wdata_i,
  output logic        alu_ready_o,
  input  logic        lsu_valid_i,
  input  logic [5:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_ready_o,
  output logic        regfile_we_o,
  output logic [5:0]  regfile_waddr_o,
  output logic [31:0] regfile_wdata_o,
`ifdef EX_WB_ARB_PERF_EN
  output logic [15:0] conflict_cnt_o,
  output logic [15:0] lsu_full_cnt_o,
`endif
  output logic        starve_o
);

  localparam int PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam int CNT_W = $clog2(LSU_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LSU_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LSU_DEPTH);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

  logic [5:0]       fifo_addr [LSU_DEPTH];
  logic [31:0]      fifo_data [LSU_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;

  logic fifo_empty;
  logic push;
  logic alu_grant;
  logic lsu_grant;

  assign fifo_empty  = (count == '0);
  // Ready depends on occupancy only; a same-cycle pop never frees a slot early.
  assign lsu_ready_o = (count < DEPTH_C);
  assign push        = lsu_valid_i & lsu_ready_o;
  assign starve_o    = (starve_cnt == STARVE_C);

  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (wb_ready_i) begin
      if (alu_valid_i && (fifo_empty || starve_o)) begin
        alu_grant = 1'b1;
      end else if (!fifo_empty) begin
        lsu_grant = 1'b1;
      end
    end
  end

  assign alu_ready_o = alu_grant;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lsu_waddr_i;
      fifo_data[wr_ptr] <= lsu_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (lsu_grant) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, lsu_grant})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Counts ALU-waiting cycles, including those stalled by the write port itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!alu_valid_i || alu_grant) begin
      starve_cnt <= '0;
    end else if (!starve_o) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Writes to x0 still consume the grant but never assert the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regfile_we_o    <= 1'b0;
      regfile_waddr_o <= '0;
      regfile_wdata_o <= '0;
    end else if (alu_grant) begin
      regfile_we_o    <= (alu_waddr_i != 6'd0);
      regfile_waddr_o <= alu_waddr_i;
      regfile_wdata_o <= alu_wdata_i;
    end else if (lsu_grant) begin
      regfile_we_o    <= (fifo_addr[rd_ptr] != 6'd0);
      regfile_waddr_o <= fifo_addr[rd_ptr];
      regfile_wdata_o <= fifo_data[rd_ptr];
    end else begin
      regfile_we_o    <= 1'b0;
    end
  end

`ifdef EX_WB_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_o <= '0;
      lsu_full_cnt_o <= '0;
    end else begin
      if (alu_valid_i && !fifo_empty && wb_ready_i && (conflict_cnt_o != 16'hFFFF)) begin
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
      if (lsu_valid_i && !lsu_ready_o && (lsu_full_cnt_o != 16'hFFFF)) begin
        lsu_full_cnt_o <= lsu_full_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_wb_port_arbiter.sv
// Randomized scoreboard bench for ex_wb_port_arbiter against a queue-based reference model.
module tb_ex_wb_port_arbiter;

  localparam int LSU_DEPTH  = 2;
  localparam int STARVE_MAX = 3;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_ready_i = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic [5:0]  alu_waddr_i = '0;
  logic [31:0] alu_wdata_i = '0;
  logic        alu_ready_o;
  logic        lsu_valid_i = 1'b0;
  logic [5:0]  lsu_waddr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic        lsu_ready_o;
  logic        regfile_we_o;
  logic [5:0]  regfile_waddr_o;
  logic [31:0] regfile_wdata_o;
  logic        starve_o;
`ifdef EX_WB_ARB_PERF_EN
  logic [15:0] conflict_cnt_o;
  logic [15:0] lsu_full_cnt_o;
`endif

  ex_wb_port_arbiter #(.LSU_DEPTH(LSU_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_ready_i      (wb_ready_i),
    .alu_valid_i     (alu_valid_i),
    .alu_waddr_i     (alu_waddr_i),
    .alu_wdata_i     (alu_wdata_i),
    .alu_ready_o     (alu_ready_o),
    .lsu_valid_i     (lsu_valid_i),
    .lsu_waddr_i     (lsu_waddr_i),
    .lsu_wdata_i     (lsu_wdata_i),
    .lsu_ready_o     (lsu_ready_o),
    .regfile_we_o    (regfile_we_o),
    .regfile_waddr_o (regfile_waddr_o),
    .regfile_wdata_o (regfile_wdata_o),
`ifdef EX_WB_ARB_PERF_EN
    .conflict_cnt_o  (conflict_cnt_o),
    .lsu_full_cnt_o  (lsu_full_cnt_o),
`endif
    .starve_o        (starve_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  wr_t fifo_m[$];
  wr_t exp_q[$];
  int  starve_m = 0;
  bit  alu_taken = 1'b0;
  bit  directed_first = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] rand_addr(input int zero_pct);
    if (int'($urandom_range(0, 99)) < zero_pct) return 6'd0;
    return 6'($urandom_range(1, 63));
  endfunction

  // Apply the arbitration rules for the cycle whose inputs are currently driven.
  task automatic model_step();
    bit alu_g;
    bit lsu_g;
    bit ready_m;
    wr_t w;
    ready_m = (fifo_m.size() < LSU_DEPTH);
    alu_g = wb_ready_i && alu_valid_i && (fifo_m.size() == 0 || starve_m == STARVE_MAX);
    lsu_g = wb_ready_i && (fifo_m.size() != 0) && !alu_g;
    chk("alu_ready", 32'(alu_ready_o), 32'(alu_g));
    chk("lsu_ready", 32'(lsu_ready_o), 32'(ready_m));
    chk("starve", 32'(starve_o), 32'(starve_m == STARVE_MAX));
    if (alu_g) begin
      w.a = alu_waddr_i;
      w.d = alu_wdata_i;
      if (w.a != 6'd0) exp_q.push_back(w);
    end
    if (lsu_g) begin
      w = fifo_m.pop_front();
      if (w.a != 6'd0) exp_q.push_back(w);
    end
    if (lsu_valid_i && ready_m) begin
      w.a = lsu_waddr_i;
      w.d = lsu_wdata_i;
      fifo_m.push_back(w);
    end
    if (!alu_valid_i || alu_g) starve_m = 0;
    else if (starve_m < STARVE_MAX) starve_m++;
    alu_taken = alu_g;
  endtask

  task automatic drive_cycle(input int p_wb, input int p_lsu, input int p_alu, input int p_zero);
    @(negedge clk);
    if (alu_taken) alu_valid_i = 1'b0;
    wb_ready_i = (int'($urandom_range(0, 99)) < p_wb);
    if (directed_first) begin
      directed_first = 1'b0;
      alu_valid_i = 1'b1;
      alu_waddr_i = 6'd5;
      alu_wdata_i = 32'hDEADBEEF;
    end else if (!alu_valid_i && int'($urandom_range(0, 99)) < p_alu) begin
      alu_valid_i = 1'b1;
      alu_waddr_i = rand_addr(p_zero);
      alu_wdata_i = $urandom;
    end
    lsu_valid_i = (int'($urandom_range(0, 99)) < p_lsu);
    lsu_waddr_i = rand_addr(p_zero);
    lsu_wdata_i = $urandom;
    #1;
    model_step();
  endtask

  task automatic reset_midflight();
    @(negedge clk);
    rst = 1'b1;
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    wb_ready_i = 1'b1;
    #1;
    chk("rst_we", 32'(regfile_we_o), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("rst_starve", 32'(starve_o), 32'd0);
    fifo_m.delete();
    exp_q.delete();
    starve_m = 0;
    alu_taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_we", 32'(regfile_we_o), 32'd0);
    model_step();
  endtask

  task automatic run_phase(input int n, input int p_wb, input int p_lsu, input int p_alu,
                           input int p_zero);
    for (int i = 0; i < n; i++) drive_cycle(p_wb, p_lsu, p_alu, p_zero);
  endtask

  initial begin
    wr_t e;
    int drained;
    #2;
    chk("reset_we", 32'(regfile_we_o), 32'd0);
    chk("reset_waddr", 32'(regfile_waddr_o), 32'd0);
    chk("reset_wdata", regfile_wdata_o, 32'd0);
    chk("reset_alu_ready", 32'(alu_ready_o), 32'd0);
    chk("reset_lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("reset_starve", 32'(starve_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (regfile_we_o === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_write got addr=%0d data=%h exp=none at %0t",
                     regfile_waddr_o, regfile_wdata_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk("wb_addr", 32'(regfile_waddr_o), 32'(e.a));
            chk("wb_data", regfile_wdata_o, e.d);
          end
        end
      end
    join_none

    run_phase(20, 100, 0, 100, 10);    // ALU only, first request is x5 <= DEADBEEF
    run_phase(30, 100, 100, 100, 5);   // sustained conflict: starvation relief
    run_phase(6, 0, 100, 100, 5);      // port stalled: FIFO fills, starve saturates
    run_phase(10, 100, 100, 100, 5);   // release with both requesters pending
    run_phase(40, 100, 50, 50, 50);    // heavy x0 traffic
    run_phase(200, 60, 50, 60, 10);
    run_phase(3, 0, 100, 100, 5);
    reset_midflight();
    run_phase(200, 60, 50, 60, 10);

    drained = 0;
    for (int i = 0; i < 50; i++) begin
      if (fifo_m.size() == 0 && !alu_valid_i) begin
        drained = 1;
        break;
      end
      drive_cycle(100, 0, 0, 0);
    end
    if (alu_taken) begin
      @(negedge clk);
      alu_valid_i = 1'b0;
    end
    chk("drain_done", 32'(drained), 32'd1);
    repeat (3) @(negedge clk);
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
